imsic_port_arbiter: RTL and testbench



---
 rtl/imsic_port_arbiter.sv | 232 +++++++++++++++++++++++
 tb/tb_imsic_port_arbiter.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imsic_port_arbiter.sv
// Round-robin arbiter sharing one IMSIC register-file port between several harts,
// with one transaction in flight and a watchdog against a stuck IMSIC.
module imsic_port_arbiter #(
    parameter int NumHarts      = 2,
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int TimeoutCycles = 255,
    localparam int HartIdW      = (NumHarts > 1) ? $clog2(NumHarts) : 1
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic [NumHarts-1:0]                 hart_req_i,
    input  logic [NumHarts-1:0]                 hart_we_i,
    input  logic [NumHarts-1:0]                 hart_claim_i,
    input  logic [NumHarts-1:0][AddrWidth-1:0]  hart_addr_i,
    input  logic [NumHarts-1:0][DataWidth-1:0]  hart_wdata_i,
    output logic [NumHarts-1:0]                 hart_gnt_o,
    output logic [NumHarts-1:0]                 hart_rvalid_o,
    output logic [DataWidth-1:0]                hart_rdata_o,
    output logic                                hart_err_o,
    output logic                                imsic_req_o,
    output logic                                imsic_we_o,
    output logic                                imsic_claim_o,
    output logic [HartIdW-1:0]                  imsic_hart_o,
    output logic [AddrWidth-1:0]                imsic_addr_o,
    output logic [DataWidth-1:0]                imsic_wdata_o,
    input  logic                                imsic_gnt_i,
    input  logic                                imsic_rvalid_i,
    input  logic [DataWidth-1:0]                imsic_rdata_i,
    input  logic                                imsic_err_i
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } state_e;

    localparam logic [HartIdW:0]      NumHartsW   = (HartIdW + 1)'(NumHarts);
    localparam logic [NumHarts-1:0]   HartOne     = NumHarts'(1);
    localparam logic [15:0]           TimeoutLast = 16'(TimeoutCycles - 1);

    state_e                 state_q;
    state_e                 state_d;
    logic [HartIdW-1:0]     rr_q;
    logic [HartIdW-1:0]     sel_q;
    logic                   we_q;
    logic                   claim_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [15:0]            cnt_q;
    logic [NumHarts-1:0]    rvalid_q;
    logic [DataWidth-1:0]   rdata_q;
    logic                   err_q;

    logic                   found_s;
    logic [HartIdW-1:0]     winner_s;
    logic [HartIdW:0]       cand_s;
    logic [HartIdW:0]       rr_next_s;
    logic                   expire_s;
    logic                   grant_s;
    logic                   enter_wait_s;
    logic                   accept_s;
    logic                   timeout_s;

    // Round-robin search: first requesting hart at or after rr_q, wrapping mod NumHarts.
    always_comb begin
        found_s  = 1'b0;
        winner_s = '0;
        cand_s   = '0;
        for (int i = 0; i < NumHarts; i++) begin
            cand_s = {1'b0, rr_q} + (HartIdW + 1)'(i);
            if (cand_s >= NumHartsW) begin
                cand_s = cand_s - NumHartsW;
            end else begin
                cand_s = cand_s;
            end
            if (!found_s && hart_req_i[cand_s[HartIdW-1:0]]) begin
                found_s  = 1'b1;
                winner_s = cand_s[HartIdW-1:0];
            end else begin
                winner_s = winner_s;
            end
        end
        rr_next_s = {1'b0, winner_s} + (HartIdW + 1)'(1);
        if (rr_next_s >= NumHartsW) begin
            rr_next_s = '0;
        end else begin
            rr_next_s = rr_next_s;
        end
    end

    // Next-state and event decode; a real downstream event beats a same-cycle timeout.
    always_comb begin
        state_d      = state_q;
        grant_s      = 1'b0;
        enter_wait_s = 1'b0;
        accept_s     = 1'b0;
        timeout_s    = 1'b0;
        expire_s     = (cnt_q == TimeoutLast);
        case (state_q)
            IDLE: begin
                if (found_s) begin
                    grant_s = 1'b1;
                    state_d = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (imsic_gnt_i) begin
                    enter_wait_s = 1'b1;
                    state_d      = WAIT;
                end else if (expire_s) begin
                    timeout_s = 1'b1;
                    state_d   = IDLE;
                end else begin
                    state_d = REQ;
                end
            end
            WAIT: begin
                if (imsic_rvalid_i) begin
                    accept_s = 1'b1;
                    state_d  = IDLE;
                end else if (expire_s) begin
                    timeout_s = 1'b1;
                    state_d   = DRAIN;
                end else begin
                    state_d = WAIT;
                end
            end
            DRAIN: begin
                if (imsic_rvalid_i) begin
                    state_d = IDLE;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (rst_i) begin
            grant_s      = 1'b0;
            enter_wait_s = 1'b0;
            accept_s     = 1'b0;
            timeout_s    = 1'b0;
        end else begin
            grant_s = grant_s;
        end
    end

    // FSM state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Request capture; rr_q advances at grant so a later timeout cannot starve anyone.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_q    <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            claim_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (grant_s) begin
            rr_q    <= rr_next_s[HartIdW-1:0];
            sel_q   <= winner_s;
            we_q    <= hart_we_i[winner_s];
            claim_q <= hart_claim_i[winner_s];
            addr_q  <= hart_addr_i[winner_s];
            wdata_q <= hart_wdata_i[winner_s];
        end else begin
            rr_q    <= rr_q;
            sel_q   <= sel_q;
            we_q    <= we_q;
            claim_q <= claim_q;
            addr_q  <= addr_q;
            wdata_q <= wdata_q;
        end
    end

    // Watchdog: restarts on entry to REQ or WAIT, advances while either is active.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= 16'd0;
        end else if (grant_s || enter_wait_s) begin
            cnt_q <= 16'd0;
        end else if ((state_q == REQ) || (state_q == WAIT)) begin
            cnt_q <= cnt_q + 16'd1;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    // Registered response pulse; write responses carry zero data.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else if (accept_s) begin
            rvalid_q <= HartOne << sel_q;
            rdata_q  <= we_q ? '0 : imsic_rdata_i;
            err_q    <= imsic_err_i;
        end else begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end
    end

    // Timeout responses are issued in the expiring cycle itself, so they are merged here.
    assign hart_gnt_o    = grant_s ? (HartOne << winner_s) : '0;
    assign hart_rvalid_o = rvalid_q | (timeout_s ? (HartOne << sel_q) : '0);
    assign hart_rdata_o  = rdata_q;
    assign hart_err_o    = err_q | timeout_s;

    assign imsic_req_o   = (state_q == REQ) && !rst_i;
    assign imsic_we_o    = we_q;
    assign imsic_claim_o = claim_q;
    assign imsic_hart_o  = sel_q;
    assign imsic_addr_o  = addr_q;
    assign imsic_wdata_o = wdata_q;

endmodule

// File: tb/tb_imsic_port_arbiter.sv
// Directed bench for imsic_port_arbiter: a deadline-based transaction model checked
// every cycle, plus hand-computed expectations for the key scenarios.
module tb_imsic_port_arbiter;

    localparam int NH = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 12;

    logic                   clk;
    logic                   rst_i;
    logic [NH-1:0]          hart_req_i;
    logic [NH-1:0]          hart_we_i;
    logic [NH-1:0]          hart_claim_i;
    logic [NH-1:0][AW-1:0]  hart_addr_i;
    logic [NH-1:0][DW-1:0]  hart_wdata_i;
    logic [NH-1:0]          hart_gnt_o;
    logic [NH-1:0]          hart_rvalid_o;
    logic [DW-1:0]          hart_rdata_o;
    logic                   hart_err_o;
    logic                   imsic_req_o;
    logic                   imsic_we_o;
    logic                   imsic_claim_o;
    logic [1:0]             imsic_hart_o;
    logic [AW-1:0]          imsic_addr_o;
    logic [DW-1:0]          imsic_wdata_o;
    logic                   imsic_gnt_i;
    logic                   imsic_rvalid_i;
    logic [DW-1:0]          imsic_rdata_i;
    logic                   imsic_err_i;

    imsic_port_arbiter #(
        .NumHarts(NH), .AddrWidth(AW), .DataWidth(DW), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .hart_req_i(hart_req_i), .hart_we_i(hart_we_i), .hart_claim_i(hart_claim_i),
        .hart_addr_i(hart_addr_i), .hart_wdata_i(hart_wdata_i),
        .hart_gnt_o(hart_gnt_o), .hart_rvalid_o(hart_rvalid_o),
        .hart_rdata_o(hart_rdata_o), .hart_err_o(hart_err_o),
        .imsic_req_o(imsic_req_o), .imsic_we_o(imsic_we_o), .imsic_claim_o(imsic_claim_o),
        .imsic_hart_o(imsic_hart_o), .imsic_addr_o(imsic_addr_o), .imsic_wdata_o(imsic_wdata_o),
        .imsic_gnt_i(imsic_gnt_i), .imsic_rvalid_i(imsic_rvalid_i),
        .imsic_rdata_i(imsic_rdata_i), .imsic_err_i(imsic_err_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is pending downstream until accepted, then awaits
    // its response; each phase has an absolute deadline cycle.
    bit          chk_en = 1'b0;
    int          cyc = 0;
    int          m_rr, m_owner, m_deadline;
    bit          m_active, m_accepted, m_orphan;
    bit          m_we, m_claim;
    logic [31:0] m_addr, m_wdata;
    bit          m_rsp_pend, m_rsp_err;
    int          m_rsp_hart;
    logic [31:0] m_rsp_data;

    always @(negedge clk) begin
        logic [NH-1:0] e_gnt, e_rv;
        logic [31:0]   e_rd;
        logic          e_err;
        int            win, h;
        bit            fire;
        if (chk_en) begin
            if (rst_i) begin
                chk("rst_gnt", 64'(hart_gnt_o), 64'd0);
                chk("rst_rvalid", 64'(hart_rvalid_o), 64'd0);
                chk("rst_rdata", 64'(hart_rdata_o), 64'd0);
                chk("rst_err", 64'(hart_err_o), 64'd0);
                chk("rst_imsic_req", 64'(imsic_req_o), 64'd0);
                chk("rst_imsic_addr", 64'(imsic_addr_o), 64'd0);
                m_rr = 0; m_active = 0; m_accepted = 0; m_orphan = 0; m_rsp_pend = 0;
            end else begin
                e_gnt = '0; e_rv = '0; e_rd = 32'd0; e_err = 1'b0;
                if (m_rsp_pend) begin
                    e_rv[m_rsp_hart] = 1'b1;
                    e_rd = m_rsp_data;
                    e_err = m_rsp_err;
                end
                win = -1;
                if (!m_active && !m_orphan) begin
                    for (int k = 0; k < NH; k++) begin
                        h = (m_rr + k) % NH;
                        if (win < 0 && hart_req_i[h]) win = h;
                    end
                end
                if (win >= 0) e_gnt[win] = 1'b1;
                fire = m_active && (cyc == m_deadline) &&
                       !(m_accepted ? imsic_rvalid_i : imsic_gnt_i);
                if (fire) begin
                    e_rv[m_owner] = 1'b1;
                    e_err = 1'b1;
                end
                chk("gnt", 64'(hart_gnt_o), 64'(e_gnt));
                chk("rvalid", 64'(hart_rvalid_o), 64'(e_rv));
                chk("rdata", 64'(hart_rdata_o), 64'(e_rd));
                chk("err", 64'(hart_err_o), 64'(e_err));
                chk("imsic_req", 64'(imsic_req_o), 64'(m_active && !m_accepted));
                if (m_active && !m_accepted) begin
                    chk("imsic_hart", 64'(imsic_hart_o), 64'(m_owner));
                    chk("imsic_addr", 64'(imsic_addr_o), 64'(m_addr));
                    chk("imsic_wdata", 64'(imsic_wdata_o), 64'(m_wdata));
                    chk("imsic_we", 64'(imsic_we_o), 64'(m_we));
                    chk("imsic_claim", 64'(imsic_claim_o), 64'(m_claim));
                end
                m_rsp_pend = m_active && m_accepted && imsic_rvalid_i;
                m_rsp_hart = m_owner;
                m_rsp_data = m_we ? 32'd0 : imsic_rdata_i;
                m_rsp_err  = imsic_err_i;
                if (win >= 0) begin
                    m_active = 1; m_accepted = 0; m_owner = win;
                    m_deadline = cyc + TO;
                    m_rr = (win + 1) % NH;
                    m_we = hart_we_i[win]; m_claim = hart_claim_i[win];
                    m_addr = hart_addr_i[win]; m_wdata = hart_wdata_i[win];
                end else if (m_active && !m_accepted) begin
                    if (imsic_gnt_i) begin
                        m_accepted = 1;
                        m_deadline = cyc + TO;
                    end else if (fire) begin
                        m_active = 0;
                    end
                end else if (m_active) begin
                    if (imsic_rvalid_i) begin
                        m_active = 0;
                    end else if (fire) begin
                        m_active = 0;
                        m_orphan = 1;
                    end
                end else if (m_orphan && imsic_rvalid_i) begin
                    m_orphan = 0;
                end
            end
        end
        cyc++;
    end

    // Stimulus helpers: harts drop req after gnt, optionally re-request after rvalid;
    // the auto responder answers one cycle after an accepted request.
    logic [NH-1:0] persist = '0;
    bit            auto_imsic = 1'b1;
    int            grant_log[$];
    logic [NH-1:0] s_gnt, s_rvalid;
    logic [31:0]   s_rdata, s_addr, s_wdata;
    logic          s_err, s_req, s_we;
    logic [1:0]    s_hart;

    task automatic tick();
        logic [NH-1:0] g, rv;
        logic          acc;
        logic [31:0]   a;
        @(negedge clk);
        #1;
        s_gnt = hart_gnt_o; s_rvalid = hart_rvalid_o; s_rdata = hart_rdata_o;
        s_err = hart_err_o; s_req = imsic_req_o; s_addr = imsic_addr_o;
        s_wdata = imsic_wdata_o; s_we = imsic_we_o; s_hart = imsic_hart_o;
        g = s_gnt; rv = s_rvalid; acc = s_req && imsic_gnt_i; a = s_addr;
        for (int h = 0; h < NH; h++) if (g[h]) grant_log.push_back(h);
        @(posedge clk);
        #1;
        for (int h = 0; h < NH; h++) begin
            if (g[h]) hart_req_i[h] = 1'b0;
            if (rv[h] && persist[h]) hart_req_i[h] = 1'b1;
        end
        if (auto_imsic) begin
            imsic_rvalid_i = acc;
            imsic_rdata_i  = {16'hC0DE, a[15:0]};
            imsic_err_i    = a[2];
        end
    endtask

    task automatic settle(input string name);
        int n;
        n = 0;
        while (n < 200 && !(hart_req_i == '0 && !m_active && !m_orphan && !m_rsp_pend)) begin
            tick();
            n++;
        end
        chk({name, "_settle_timeout"}, 64'(n >= 200), 64'd0);
    endtask

    initial begin
        int n0;
        #100000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int n0, n;
        rst_i = 1'b1;
        hart_req_i = 4'b1111;
        hart_we_i = 4'b1010;
        hart_claim_i = 4'b0100;
        for (int h = 0; h < NH; h++) begin
            hart_addr_i[h]  = 32'h100 + 32'(4 * h);
            hart_wdata_i[h] = 32'hA000_0000 + 32'(h);
        end
        imsic_gnt_i = 1'b1; imsic_rvalid_i = 1'b0;
        imsic_rdata_i = 32'd0; imsic_err_i = 1'b0;

        // 1: reset with everybody requesting, then first grant to hart 0.
        @(posedge clk); #1;
        chk_en = 1'b1;
        tick();
        chk("t1_rst_gnt", 64'(s_gnt), 64'd0);
        chk("t1_rst_req", 64'(s_req), 64'd0);
        rst_i = 1'b0;
        tick();
        chk("t1_first_gnt", 64'(s_gnt), 64'b0001);
        settle("t1");
        chk("t1_order_len", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < 4; i++) chk("t1_order", 64'(grant_log[i]), 64'(i));

        // 3: continuous requests from all harts, eight transactions.
        n0 = grant_log.size();
        persist = 4'b1111;
        hart_req_i = 4'b1111;
        n = 0;
        while (n < 100 && grant_log.size() < n0 + 8) begin
            tick();
            n++;
        end
        persist = '0;
        hart_req_i = '0;
        settle("t3");
        chk("t3_count", 64'(grant_log.size()), 64'(n0 + 8));
        for (int i = 0; i < 8; i++) chk("t3_order", 64'(grant_log[n0 + i]), 64'(i % 4));

        // 2: single read by hart 1, downstream gnt immediately, rvalid two cycles later.
        auto_imsic = 1'b0;
        hart_addr_i[1] = 32'h70; hart_we_i[1] = 1'b0;
        hart_req_i[1] = 1'b1; imsic_gnt_i = 1'b1;
        tick();
        chk("t2_gnt", 64'(s_gnt), 64'b0010);
        tick();
        chk("t2_imsic_req", 64'(s_req), 64'd1);
        chk("t2_imsic_addr", 64'(s_addr), 64'h70);
        chk("t2_imsic_hart", 64'(s_hart), 64'd1);
        imsic_gnt_i = 1'b0;
        tick();
        imsic_rvalid_i = 1'b1; imsic_rdata_i = 32'hDEAD_BEEF; imsic_err_i = 1'b0;
        tick();
        chk("t2_rvalid_early", 64'(s_rvalid), 64'd0);
        imsic_rvalid_i = 1'b0;
        tick();
        chk("t2_rvalid", 64'(s_rvalid), 64'b0010);
        chk("t2_rdata", 64'(s_rdata), 64'hDEAD_BEEF);
        chk("t2_err", 64'(s_err), 64'd0);

        // 4: downstream stall for 10 cycles with another hart waiting.
        hart_addr_i[2] = 32'h44; hart_wdata_i[2] = 32'h1234_5678; hart_we_i[2] = 1'b1;
        hart_req_i[2] = 1'b1;
        tick();
        chk("t4_gnt", 64'(s_gnt), 64'b0100);
        hart_req_i[3] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t4_req_held", 64'(s_req), 64'd1);
            chk("t4_addr_held", 64'(s_addr), 64'h44);
            chk("t4_wdata_held", 64'(s_wdata), 64'h1234_5678);
            chk("t4_we_held", 64'(s_we), 64'd1);
            chk("t4_no_gnt", 64'(s_gnt), 64'd0);
        end
        imsic_gnt_i = 1'b1; auto_imsic = 1'b1;
        settle("t4");
        chk("t4_next_gnt", 64'(grant_log[grant_log.size() - 1]), 64'd3);

        // 5a: no downstream gnt; error response in the TO-th request cycle.
        auto_imsic = 1'b0; imsic_gnt_i = 1'b0; imsic_rvalid_i = 1'b0;
        hart_req_i[0] = 1'b1;
        tick();
        chk("t5a_gnt", 64'(s_gnt), 64'b0001);
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("t5a_no_rvalid", 64'(s_rvalid), 64'd0);
        end
        tick();
        chk("t5a_rvalid", 64'(s_rvalid), 64'b0001);
        chk("t5a_err", 64'(s_err), 64'd1);
        chk("t5a_rdata", 64'(s_rdata), 64'd0);
        chk("t5a_req_last", 64'(s_req), 64'd1);
        tick();
        chk("t5a_req_dropped", 64'(s_req), 64'd0);
        chk("t5a_rvalid_once", 64'(s_rvalid), 64'd0);

        // 5b: gnt then no response; timeout, drain of the late rvalid, then next grant.
        hart_req_i[1] = 1'b1;
        tick();
        chk("t5b_gnt", 64'(s_gnt), 64'b0010);
        imsic_gnt_i = 1'b1;
        tick();
        imsic_gnt_i = 1'b0;
        for (int i = 0; i < TO - 1; i++) begin
            tick();
            chk("t5b_no_rvalid", 64'(s_rvalid), 64'd0);
        end
        tick();
        chk("t5b_rvalid", 64'(s_rvalid), 64'b0010);
        chk("t5b_err", 64'(s_err), 64'd1);
        chk("t5b_rdata", 64'(s_rdata), 64'd0);
        hart_req_i[2] = 1'b1;
        tick();
        chk("t5b_drain_no_gnt", 64'(s_gnt), 64'd0);
        imsic_rvalid_i = 1'b1; imsic_rdata_i = 32'h5555_5555; imsic_err_i = 1'b0;
        tick();
        chk("t5b_drain_no_gnt2", 64'(s_gnt), 64'd0);
        chk("t5b_drain_no_rvalid", 64'(s_rvalid), 64'd0);
        imsic_rvalid_i = 1'b0;
        tick();
        chk("t5b_post_drain_gnt", 64'(s_gnt), 64'b0100);
        chk("t5b_discarded", 64'(s_rvalid), 64'd0);
        imsic_gnt_i = 1'b1; auto_imsic = 1'b1;
        settle("t5b");

        // 6: response arrives in the very cycle the watchdog expires.
        auto_imsic = 1'b0; imsic_gnt_i = 1'b0; imsic_rvalid_i = 1'b0;
        hart_we_i[3] = 1'b0;
        hart_req_i[3] = 1'b1;
        tick();
        chk("t6_gnt", 64'(s_gnt), 64'b1000);
        imsic_gnt_i = 1'b1;
        tick();
        imsic_gnt_i = 1'b0;
        for (int i = 0; i < TO - 1; i++) tick();
        imsic_rvalid_i = 1'b1; imsic_rdata_i = 32'hCAFE_F00D; imsic_err_i = 1'b0;
        tick();
        chk("t6_no_timeout_rsp", 64'(s_rvalid), 64'd0);
        chk("t6_no_timeout_err", 64'(s_err), 64'd0);
        imsic_rvalid_i = 1'b0;
        hart_req_i[0] = 1'b1;
        tick();
        chk("t6_rvalid", 64'(s_rvalid), 64'b1000);
        chk("t6_rdata", 64'(s_rdata), 64'hCAFE_F00D);
        chk("t6_err", 64'(s_err), 64'd0);
        chk("t6_idle_gnt", 64'(s_gnt), 64'b0001);
        imsic_gnt_i = 1'b1; auto_imsic = 1'b1;
        settle("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
